// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with byte-lane writes, pipelined reads (latency 1 or 2),
// a post-reset zeroing sweep that gates Ready, and out-of-range access flagging.
module data_memory_ctrl #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [ADDR_WIDTH-1:0]   Adresa,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  input  logic                    MemWrite,
  input  logic                    MemRead,
  output logic                    Ready,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  output logic                    AddrError
);

  localparam int unsigned         NB    = DATA_WIDTH / 8;
  localparam int unsigned         IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]       LAST  = IW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  run, in_range, wr_acc, rd_acc;
  logic [IW-1:0]         aidx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  cv, ce;
  logic [DATA_WIDTH-1:0] cd;

  always_comb begin
    run      = (state == RUN);
    in_range = ({1'b0, Adresa} < LIMIT);
    aidx     = Adresa[IW-1:0];
    wr_acc   = run && MemWrite;
    rd_acc   = run && MemRead && !MemWrite;
    rd_word  = in_range ? mem[aidx] : '0;
  end

  // Array has no reset; the sweep zeroes it one word per cycle after reset release.
  always_ff @(posedge Clock) begin
    if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (ByteEn[i]) mem[aidx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  pv, pe;
      logic [DATA_WIDTH-1:0] pd;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          pv <= 1'b0;
          pe <= 1'b0;
          pd <= '0;
        end else begin
          pv <= rd_acc;
          pe <= rd_acc && !in_range;
          pd <= rd_word;
        end
      end

      always_comb begin
        cv = pv;
        ce = pe;
        cd = pd;
      end
    end else begin : g_lat1
      always_comb begin
        cv = rd_acc;
        ce = rd_acc && !in_range;
        cd = rd_word;
      end
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= CLEAR;
      idx       <= '0;
      Ready     <= 1'b0;
      ReadData  <= '0;
      ReadValid <= 1'b0;
      AddrError <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        idx <= idx + 1'b1;
        if (idx == LAST) begin
          state <= RUN;
          Ready <= 1'b1;
        end
      end
      ReadValid <= cv;
      if (cv) ReadData <= cd;
      // With latency 2 a write error can coincide with a delayed read error.
      AddrError <= ce || (wr_acc && !in_range);
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at read latency 1 and one at 2,
// both driven by the same stimulus.
module tb_data_memory_ctrl;

  logic        clk, rst_n;
  logic [15:0] adresa, wdata;
  logic [1:0]  be;
  logic        mwr, mrd;
  logic        ready1, rv1, err1, ready2, rv2, err2;
  logic [15:0] rdata1, rdata2;

  int checks   = 0;
  int failures = 0;

  data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(1)) dut (
    .Clock(clk), .Reset(rst_n), .Adresa(adresa), .WriteData(wdata), .ByteEn(be),
    .MemWrite(mwr), .MemRead(mrd), .Ready(ready1), .ReadData(rdata1),
    .ReadValid(rv1), .AddrError(err1)
  );

  data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(2)) dut2 (
    .Clock(clk), .Reset(rst_n), .Adresa(adresa), .WriteData(wdata), .ByteEn(be),
    .MemWrite(mwr), .MemRead(mrd), .Ready(ready2), .ReadData(rdata2),
    .ReadValid(rv2), .AddrError(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    adresa = a; wdata = d; be = b; mwr = 1'b1;
    step();
    mwr = 1'b0;
  endtask

  // Counts edges until Ready rises; flags any ReadValid seen meanwhile.
  task automatic wait_sweep(input string tag);
    int n = 0;
    bit bad_rv = 0;
    while (!ready1 && n < 400) begin
      step();
      n++;
      if (!ready1 && (rv1 || rv2)) bad_rv = 1;
    end
    checks++;
    if (n !== 256) begin
      failures++; $display("FAIL %s_sweep_len got=%0d exp=256", tag, n);
    end
    checks++;
    if (bad_rv !== 1'b0) begin
      failures++; $display("FAIL %s_rv_during_sweep got=1 exp=0", tag);
    end
    checks++;
    if (ready2 !== 1'b1) begin
      failures++; $display("FAIL %s_ready_lat2 got=%b exp=1", tag, ready2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adresa = '0; wdata = '0; be = '0; mwr = 1'b0; mrd = 1'b0;
    repeat (2) step();
    checks++;
    if ({ready1, rv1, err1, rdata1} !== 19'd0) begin
      failures++; $display("FAIL reset_outputs got=%b/%b/%b/%h exp=0/0/0/0000", ready1, rv1, err1, rdata1);
    end
    rst_n = 1'b1;
    adresa = 16'd5; mrd = 1'b1;
    wait_sweep("init");
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0000) begin
      failures++; $display("FAIL first_read got=rv%b/%h exp=rv1/0000", rv1, rdata1);
    end
    checks++;
    if (rv2 !== 1'b0) begin
      failures++; $display("FAIL first_read_lat2_early got=%b exp=0", rv2);
    end
    step();
    checks++;
    if (rv2 !== 1'b1 || rdata2 !== 16'h0000 || rv1 !== 1'b0) begin
      failures++; $display("FAIL first_read_lat2 got=rv2 %b/%h rv1 %b exp=1/0000/0", rv2, rdata2, rv1);
    end
    step();
  endtask

  task automatic test_write_read();
    do_write(16'd12, 16'h0007, 2'b11);
    checks++;
    if (err1 !== 1'b0) begin
      failures++; $display("FAIL wr12_err got=%b exp=0", err1);
    end
    adresa = 16'h000C; mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0007 || err1 !== 1'b0) begin
      failures++; $display("FAIL raw12 got=%b/%h/%b exp=1/0007/0", rv1, rdata1, err1);
    end
    step(); step();
  endtask

  task automatic test_byte_en();
    do_write(16'd3, 16'hABCD, 2'b11);
    do_write(16'd3, 16'h1200, 2'b10);
    adresa = 16'd3; mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h12CD) begin
      failures++; $display("FAIL byte_hi got=%b/%h exp=1/12CD", rv1, rdata1);
    end
    do_write(16'd3, 16'hFFFF, 2'b00);
    checks++;
    if (rv1 !== 1'b0 || rdata1 !== 16'h12CD) begin
      failures++; $display("FAIL rdata_hold got=%b/%h exp=0/12CD", rv1, rdata1);
    end
    adresa = 16'd3; mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h12CD) begin
      failures++; $display("FAIL byte_none got=%b/%h exp=1/12CD", rv1, rdata1);
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    mrd = 1'b1; adresa = 16'd12;
    step();
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0007 || rv2 !== 1'b0) begin
      failures++; $display("FAIL b2b_0 got=%b/%h rv2=%b exp=1/0007/0", rv1, rdata1, rv2);
    end
    adresa = 16'd3;
    step();
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h12CD || rv2 !== 1'b1 || rdata2 !== 16'h0007) begin
      failures++; $display("FAIL b2b_1 got=%b/%h %b/%h exp=1/12CD 1/0007", rv1, rdata1, rv2, rdata2);
    end
    adresa = 16'd12;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0007 || rv2 !== 1'b1 || rdata2 !== 16'h12CD || ready1 !== 1'b1) begin
      failures++; $display("FAIL b2b_2 got=%b/%h %b/%h rdy=%b exp=1/0007 1/12CD 1", rv1, rdata1, rv2, rdata2, ready1);
    end
    step();
    checks++;
    if (rv1 !== 1'b0 || rv2 !== 1'b1 || rdata2 !== 16'h0007) begin
      failures++; $display("FAIL b2b_tail got=%b %b/%h exp=0 1/0007", rv1, rv2, rdata2);
    end
    step();
  endtask

  task automatic test_wr_rd_conflict();
    adresa = 16'd12; wdata = 16'h0055; be = 2'b11; mwr = 1'b1; mrd = 1'b1;
    step();
    mwr = 1'b0; mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b0) begin
      failures++; $display("FAIL conflict_rv got=%b exp=0", rv1);
    end
    step();
    checks++;
    if (rv2 !== 1'b0) begin
      failures++; $display("FAIL conflict_rv_lat2 got=%b exp=0", rv2);
    end
    mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0055) begin
      failures++; $display("FAIL conflict_data got=%b/%h exp=1/0055", rv1, rdata1);
    end
    step(); step();
  endtask

  task automatic test_out_of_range();
    adresa = 16'd300; mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0000 || err1 !== 1'b1) begin
      failures++; $display("FAIL oor_read got=%b/%h/%b exp=1/0000/1", rv1, rdata1, err1);
    end
    step();
    checks++;
    if (err1 !== 1'b0 || rv2 !== 1'b1 || rdata2 !== 16'h0000 || err2 !== 1'b1) begin
      failures++; $display("FAIL oor_read_lat2 got=err1 %b %b/%h/%b exp=0 1/0000/1", err1, rv2, rdata2, err2);
    end
    step();
    do_write(16'd300, 16'hFFFF, 2'b11);
    checks++;
    if (err1 !== 1'b1 || rv1 !== 1'b0) begin
      failures++; $display("FAIL oor_write_err got=%b rv=%b exp=1/0", err1, rv1);
    end
    step();
    checks++;
    if (err1 !== 1'b0) begin
      failures++; $display("FAIL oor_write_pulse got=%b exp=0", err1);
    end
    adresa = 16'd44; mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0000 || err1 !== 1'b0) begin
      failures++; $display("FAIL no_alias44 got=%b/%h/%b exp=1/0000/0", rv1, rdata1, err1);
    end
    step(); step();
  endtask

  task automatic test_reset_midflight();
    adresa = 16'd12; mrd = 1'b1;
    step();
    mrd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready1, rv1, rdata1, ready2, rv2, rdata2} !== 36'd0) begin
      failures++; $display("FAIL async_reset got=%b/%b/%h %b/%b/%h exp=all 0", ready1, rv1, rdata1, ready2, rv2, rdata2);
    end
    step();
    checks++;
    if (rv2 !== 1'b0) begin
      failures++; $display("FAIL inflight_flushed got=%b exp=0", rv2);
    end
    rst_n = 1'b1;
    wait_sweep("rerun");
    adresa = 16'd12; mrd = 1'b1;
    step();
    mrd = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 16'h0000) begin
      failures++; $display("FAIL post_reset_12 got=%b/%h exp=1/0000", rv1, rdata1);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_en();
    test_back_to_back();
    test_wr_rd_conflict();
    test_out_of_range();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised word-addressed data memory for the CPU data path: generic data width and depth, byte-lane write enables, pipelined reads with configurable latency, and a read-valid strobe. After reset it runs a self-clearing sweep that zeroes every word and holds Ready low until the sweep finishes. Out-of-range accesses are flagged rather than aliased. It sits between the execute stage (address/store data) and the write-back mux (load data).

Parameters:
DATA_WIDTH, 16, data word width in bits; must be a multiple of 8.
ADDR_WIDTH, 16, width of Adresa; must be >= clog2(DEPTH).
DEPTH, 256, number of words.
READ_LATENCY, 1, cycles from read acceptance to ReadValid; legal values 1 or 2.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
Adresa  input  ADDR_WIDTH  word address.
WriteData  input  DATA_WIDTH  store data.
ByteEn  input  DATA_WIDTH/8  per-byte write enable; bit i covers WriteData[8i+7:8i].
MemWrite  input  1  write request.
MemRead  input  1  read request.
Ready  output  1  1 = requests accepted this cycle.
ReadData  output  DATA_WIDTH  load data.
ReadValid  output  1  1-cycle strobe; ReadData is valid.
AddrError  output  1  1-cycle strobe; last access was out of range.

Behaviour:
- Reset (Reset=0, asynchronous): Ready=0, ReadData=0, ReadValid=0, AddrError=0. Read pipeline flushed, clear index=0, FSM enters CLEAR. Reset asserted mid-operation aborts everything, including a partial sweep and in-flight reads. The sweep restarts from word 0 after release.
- FSM states: CLEAR and RUN.
- CLEAR: one word per cycle, mem[idx] <= 0, idx++. On the edge that writes word DEPTH-1, go to RUN; Ready=1 from the next cycle. Ready is therefore 0 for exactly DEPTH cycles after reset release.
- While Ready=0, MemWrite and MemRead are ignored. No write, no response, no error.
- RUN, write: accepted on an edge when MemWrite=1.
  - If Adresa < DEPTH, each byte lane with ByteEn[i]=1 is updated; other lanes keep their value.
  - ByteEn all-zero is a legal no-op.
- RUN, read: accepted on an edge when MemRead=1 and MemWrite=0.
  - ReadValid=1 exactly READ_LATENCY cycles after the accepting edge, with ReadData = mem[Adresa] sampled at acceptance.
  - Reads are fully pipelined: one per cycle, back-to-back, and Ready stays 1.
- MemWrite=1 and MemRead=1 together: the write executes and the read is dropped. No ReadValid is produced.
- Read-after-write: a read accepted on the edge after a write to the same address returns the new data. No stale-data hazard.
- Out of range (Adresa >= DEPTH):
  - Write: memory unchanged; AddrError=1 for one cycle after the accepting edge.
  - Read: ReadValid is still produced at normal latency, with ReadData=0 and AddrError=1 on the same cycle as ReadValid.
- ReadData holds its last value while ReadValid=0. It changes only when a read completes or on reset.
- Only Adresa[clog2(DEPTH)-1:0] indexes the array, and only after the range check passes. There is no wrap-around aliasing.

Test Plan:
- Release Reset, hold MemRead=1 at Adresa=5 throughout -> Ready=0 for 256 cycles, 1 from cycle 256; no ReadValid while Ready=0; first accepted read returns 0x0000 with ReadValid one cycle later.
- Write Adresa=12, WriteData=0x0007, ByteEn=2'b11; next cycle read Adresa=0x0C -> ReadValid=1 one cycle later with ReadData=0x0007, AddrError=0.
- Write 0xABCD to addr 3 (ByteEn=11), then 0x1200 with ByteEn=10, then read addr 3 -> 0x12CD; a write with ByteEn=00 leaves 0x12CD.
- Reads on three consecutive cycles at addr 12, 3, 12 -> ReadValid high three consecutive cycles with 0x0007, 0x12CD, 0x0007. With READ_LATENCY=2 the same sequence is shifted one cycle later. Simultaneous MemWrite+MemRead at addr 12 with 0x0055 -> no ReadValid; a later read gives 0x0055.
- Read Adresa=300 -> ReadValid=1, ReadData=0x0000, AddrError=1 on the same cycle. Write 0xFFFF to 300 -> one-cycle AddrError pulse; addr 44 (300 mod 256) still reads 0x0000.
- Pull Reset low while a read is in flight -> ReadValid, ReadData and Ready drop to 0 immediately with no clock edge; after release the 256-cycle sweep reruns and addr 12 reads 0x0000.
